// File: rtl/vga_console_writer.sv
// Character-stream writer for the VGA text console frame buffer (port A only).
// Tracks the cursor, interprets CR/LF/BS/FF, and scrolls by copying rows up one line.
module vga_console_writer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     char_valid,
  input  logic [DATA_WIDTH-1:0]    char_data,
  output logic                     char_ready,
  output logic                     ram_we,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic [$clog2(ROWS)-1:0]  cursor_row,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic                     busy
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [ADDR_WIDTH-1:0] COLS_A        = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(ROWS*COLS-1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW_BASE = ADDR_WIDTH'((ROWS-1)*COLS);
  localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(8'h7E);
  localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8'h08);
  localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CH_FF    = DATA_WIDTH'(8'h0C);
  localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);

  typedef enum logic [2:0] {IDLE, SCROLL_RD, SCROLL_WR, CLEAR_ROW, CLEAR_ALL} state_t;

  state_t                  state_reg;
  logic                    scroll_pend_reg;
  logic                    ram_we_reg;
  logic [ADDR_WIDTH-1:0]   ram_addr_reg;
  logic [ADDR_WIDTH-1:0]   src_reg;
  logic [DATA_WIDTH-1:0]   ram_din_reg;
  logic [RW-1:0]           row_reg;
  logic [CW-1:0]           col_reg;

  logic                    accept;
  logic                    printable;
  logic                    col_last;
  logic                    row_last;
  logic [ADDR_WIDTH-1:0]   cursor_addr;

  // A printable byte that wraps off the last row still needs its own write
  // cycle, so the scroll is held pending for one cycle behind it.
  assign char_ready  = (state_reg == IDLE) && !scroll_pend_reg && !reset;
  assign accept      = char_valid && char_ready;
  assign printable   = (char_data >= CH_SPACE) && (char_data <= CH_TILDE);
  assign col_last    = (col_reg == CW'(COLS-1));
  assign row_last    = (row_reg == RW'(ROWS-1));
  assign cursor_addr = ADDR_WIDTH'(row_reg) * COLS_A + ADDR_WIDTH'(col_reg);

  assign busy       = (state_reg != IDLE) || scroll_pend_reg;
  assign ram_we     = ram_we_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_din    = (state_reg == SCROLL_WR) ? ram_dout : ram_din_reg;
  assign cursor_row = row_reg;
  assign cursor_col = col_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      scroll_pend_reg <= 1'b0;
      ram_we_reg      <= 1'b0;
      ram_addr_reg    <= '0;
      ram_din_reg     <= '0;
      src_reg         <= '0;
      row_reg         <= '0;
      col_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ram_we_reg <= 1'b0;
          if (scroll_pend_reg) begin
            scroll_pend_reg <= 1'b0;
            state_reg       <= SCROLL_RD;
            ram_addr_reg    <= COLS_A;
            src_reg         <= COLS_A;
          end else if (accept) begin
            if (printable) begin
              ram_we_reg   <= 1'b1;
              ram_addr_reg <= cursor_addr;
              ram_din_reg  <= char_data;
              if (col_last) begin
                col_reg <= '0;
                if (row_last) scroll_pend_reg <= 1'b1;
                else          row_reg <= row_reg + RW'(1);
              end else begin
                col_reg <= col_reg + CW'(1);
              end
            end else if (char_data == CH_LF) begin
              col_reg <= '0;
              if (row_last) begin
                state_reg    <= SCROLL_RD;
                ram_addr_reg <= COLS_A;
                src_reg      <= COLS_A;
              end else begin
                row_reg <= row_reg + RW'(1);
              end
            end else if (char_data == CH_CR) begin
              col_reg <= '0;
            end else if (char_data == CH_BS) begin
              if (col_reg != '0) begin
                col_reg      <= col_reg - CW'(1);
                ram_we_reg   <= 1'b1;
                ram_addr_reg <= cursor_addr - ADDR_WIDTH'(1);
                ram_din_reg  <= CH_SPACE;
              end
            end else if (char_data == CH_FF) begin
              state_reg    <= CLEAR_ALL;
              row_reg      <= '0;
              col_reg      <= '0;
              ram_we_reg   <= 1'b1;
              ram_addr_reg <= '0;
              ram_din_reg  <= CH_SPACE;
            end
          end
        end
        SCROLL_RD: begin
          state_reg    <= SCROLL_WR;
          ram_we_reg   <= 1'b1;
          ram_addr_reg <= src_reg - COLS_A;
        end
        SCROLL_WR: begin
          src_reg <= src_reg + ADDR_WIDTH'(1);
          if (src_reg == LAST_ADDR) begin
            state_reg    <= CLEAR_ROW;
            ram_we_reg   <= 1'b1;
            ram_addr_reg <= LAST_ROW_BASE;
            ram_din_reg  <= CH_SPACE;
          end else begin
            state_reg    <= SCROLL_RD;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= src_reg + ADDR_WIDTH'(1);
          end
        end
        CLEAR_ROW, CLEAR_ALL: begin
          // Both clears run up to the last cell of the screen.
          if (ram_addr_reg == LAST_ADDR) begin
            state_reg  <= IDLE;
            ram_we_reg <= 1'b0;
          end else begin
            ram_addr_reg <= ram_addr_reg + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_reg  <= IDLE;
          ram_we_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule
